roulette_stop: RTL
==================

# roulette_stop

Input side of the roulette display path: reads a raw push-button, synchronizes and debounces it, and runs a RUN/STOP state machine. On each stop it freezes the roulette and captures the six-bit one-hot ring position being driven to the seven-segment display. It decodes that position to an index and to an active-low seven-segment digit (1–6). It sits between the board key input and the roulette ring, and gates the ring's advance through `run`.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a key level change (10 ms at 50 MHz); minimum 2.
- `CNT_W`, default 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- `clk` in 1: single clock, CLOCK_50 domain; all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_n` in 1: raw asynchronous push-button, active-low (0 = pressed).
- `seg_in` in 6: ring position from the roulette, one-hot, bit i = segment i.
- `run` out 1: 1 = roulette may advance, 0 = frozen.
- `hit_valid` out 1: one-cycle pulse when a position is captured.
- `hit_idx` out 3: captured index 0–5; 7 = invalid capture.
- `hit_hex` out 7: active-low gfedcba digit for the captured value.
- `seg_err` out 1: last capture was not exactly one-hot.
- `hit_count` out 8: number of stops since reset.

## Operation
- Synchronizer: two flops, `sync1`/`sync2`, reset to 1.
- Debounce: register `stable`, reset 1, plus counter `cnt`, reset 0.
  - When `sync2 == stable`: `cnt` clears.
  - Otherwise `cnt` increments.
  - When `cnt == DEBOUNCE_CYCLES-1` and `sync2 != stable`: `stable <= sync2` and `cnt <= 0`.
  - Any bounce back to the `stable` level before that point restarts the count.
- Press detect: `press` register pulses 1 for one cycle when `stable` falls 1→0. Release (0→1) produces no pulse.
- FSM, states RUN and STOP; reset state RUN.
  - RUN: `run=1`. On `press`: sample `seg_in`, update `hit_idx`, `hit_hex` and `seg_err`, pulse `hit_valid`, increment `hit_count`, go to STOP.
  - STOP: `run=0`. On `press`: go to RUN. Capture outputs keep their values; no `hit_valid`.
- Decode, using `seg_in` as sampled on the capture edge:
  - Exactly one bit i set: `hit_idx=i`, `seg_err=0`, `hit_hex` = digit i+1.
  - Digits 1..6 = 1111001, 0100100, 0110000, 0011001, 0010010, 0000010.
  - Zero or multiple bits set: `hit_idx=7`, `seg_err=1`, `hit_hex=0000110` ("E").
- `hit_count`: 8-bit, wraps 255→0.
- Reset values: `run=1`, `hit_valid=0`, `hit_idx=0`, `hit_hex=1111111` (blank), `seg_err=0`, `hit_count=0`.

## Timing
- Count edges with edge 1 = first rising edge sampling `key_n=0`, key held low thereafter:
  - `sync2` low after edge 2.
  - `stable` falls at edge DEBOUNCE_CYCLES+2.
  - `press` high for the cycle after edge DEBOUNCE_CYCLES+3.
  - FSM transition, capture and `hit_valid` high for the cycle after edge DEBOUNCE_CYCLES+4.
- `run` changes on the same edge as the FSM transition. Ring advance on the following edges is the roulette's concern.
- `hit_valid` is never high for two consecutive cycles.
- Capture uses `seg_in` as present before the capture edge. A ring shift landing on that same edge is not seen.
- Reset mid-debounce or mid-STOP returns to reset values with no pulse. A key still held low through reset is treated as a fresh press: `press` fires DEBOUNCE_CYCLES+3 edges after reset deasserts.
- `rst` has priority over every other event.

## Configuration
- `ROULETTE_STOP_HIT_CNT_EN` defined: `hit_count` counter is implemented as described.
- Undefined: no counter register; `hit_count` is tied to 0. All other behaviour is unchanged.

## Test plan
- All tests use `DEBOUNCE_CYCLES=4`.
- Reset held 3 cycles with `key_n=1` -> `run=1`, `hit_hex=1111111`, `hit_idx=0`, `hit_valid=0`, `hit_count=0`.
- `seg_in=000100`, `key_n` low from edge 1 -> `hit_valid` high only after edge 8; `hit_idx=2`, `hit_hex=0110000`, `run=0`, `hit_count=1`.
- Bounce: `key_n` low 3 cycles, high 1, low 3, then high -> no `press`, no `hit_valid`, state stays RUN.
- From STOP: release, then press again -> `run=1` after the transition edge, no `hit_valid`, `hit_idx` still 2. Third press with `seg_in=100000` -> `hit_idx=5`, `hit_hex=0000010`, `hit_count=2`.
- Capture with `seg_in=000000`, and separately with `seg_in=010010` -> `hit_idx=7`, `seg_err=1`, `hit_hex=0000110`.
- Reset asserted while `cnt=2` with key held low -> no pulse during reset. `hit_valid` occurs 8 edges after reset release. Without `ROULETTE_STOP_HIT_CNT_EN`, `hit_count` stays 0 throughout.

Source files
------------

// File: rtl/roulette_stop_if.sv
// roulette_stop_if: key/ring inputs and capture outputs of the roulette stop block.
interface roulette_stop_if;
    logic       key_n;
    logic [5:0] seg_in;
    logic       run;
    logic       hit_valid;
    logic [2:0] hit_idx;
    logic [6:0] hit_hex;
    logic       seg_err;
    logic [7:0] hit_count;
    modport slave (
        input  key_n, seg_in,
        output run, hit_valid, hit_idx, hit_hex, seg_err, hit_count
    );
    modport master (
        output key_n, seg_in,
        input  run, hit_valid, hit_idx, hit_hex, seg_err, hit_count
    );
endinterface

// File: rtl/roulette_stop.sv
// roulette_stop: debounced key drives a RUN/STOP FSM that captures and decodes the ring position.
// Define ROULETTE_STOP_HIT_CNT_EN to implement the hit_count stop counter (otherwise tied to 0).
module roulette_stop #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input logic           clk,
    input logic           rst,
    roulette_stop_if.slave bus
);
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] STOP = 1'b1;

    logic             sync1_q, sync2_q, stable_q, stable_d, stable_dly_q;
    logic             press_q, press_d, hit_valid_q, seg_err_q, seg_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [0:0]       state_q, state_d;
    logic [2:0]       hit_idx_q, hit_idx_d, cap_idx;
    logic [6:0]       hit_hex_q, hit_hex_d, cap_hex;
    logic             capture;

    assign capture = press_q && state_q == RUN;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end
        end
        press_d   = stable_dly_q & ~stable_q;
        state_d   = press_q ? ~state_q : state_q;
        hit_idx_d = capture ? cap_idx : hit_idx_q;
        hit_hex_d = capture ? cap_hex : hit_hex_q;
        seg_err_d = capture ? (cap_idx == 3'd7) : seg_err_q;
    end

    // Anything other than exactly one set bit decodes to index 7 / "E".
    always_comb begin
        cap_idx = 3'd7;
        for (int i = 0; i < 6; i++)
            cap_idx = (bus.seg_in == 6'(1 << i)) ? 3'(i) : cap_idx;
        case (cap_idx)
            3'd0:    cap_hex = 7'b1111001;
            3'd1:    cap_hex = 7'b0100100;
            3'd2:    cap_hex = 7'b0110000;
            3'd3:    cap_hex = 7'b0011001;
            3'd4:    cap_hex = 7'b0010010;
            3'd5:    cap_hex = 7'b0000010;
            default: cap_hex = 7'b0000110;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            stable_q     <= 1'b1;
            stable_dly_q <= 1'b1;
            cnt_q        <= '0;
            press_q      <= 1'b0;
            state_q      <= RUN;
            hit_valid_q  <= 1'b0;
            hit_idx_q    <= 3'd0;
            hit_hex_q    <= 7'b1111111;
            seg_err_q    <= 1'b0;
        end else begin
            sync1_q      <= bus.key_n;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
            press_q      <= press_d;
            state_q      <= state_d;
            hit_valid_q  <= capture;
            hit_idx_q    <= hit_idx_d;
            hit_hex_q    <= hit_hex_d;
            seg_err_q    <= seg_err_d;
        end
    end

`ifdef ROULETTE_STOP_HIT_CNT_EN
    logic [7:0] hit_count_q, hit_count_d;
    assign hit_count_d = capture ? hit_count_q + 8'd1 : hit_count_q;
    always_ff @(posedge clk) begin
        if (rst) hit_count_q <= 8'd0;
        else     hit_count_q <= hit_count_d;
    end
    assign bus.hit_count = hit_count_q;
`else
    assign bus.hit_count = 8'd0;
`endif

    assign bus.run       = (state_q == RUN);
    assign bus.hit_valid = hit_valid_q;
    assign bus.hit_idx   = hit_idx_q;
    assign bus.hit_hex   = hit_hex_q;
    assign bus.seg_err   = seg_err_q;
endmodule
